// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Program-counter sequencer with BOOT/RUN/HALT control. It advances
//            the PC by STEP when downstream is ready, applies redirects
//            (buffering one while stalled), vectors to TRAP_VEC on trap or on
//            a misaligned redirect, and supports halt/resume.
// Ports    : clk, rst              - clock, synchronous active-high reset
//            ready                 - downstream accepts current PC
//            redirect_valid/target - branch/jump request and target
//            trap_req              - exception request
//            halt_req, resume      - enter / leave HALT
//            pc                    - registered current PC
//            pc_plus_step          - pc + STEP (combinational, wraps)
//            pc_valid, halted      - RUN / HALT state indicators
//            pending               - a redirect target is buffered
//            misalign              - one-cycle pulse on misaligned redirect
// Revision : 1.0  initial release
// ============================================================================
module pc_sequencer #(
   parameter int unsigned     XLEN       = 32,
   parameter int unsigned     STEP       = 1,
   parameter logic [XLEN-1:0] RESET_ADDR = '0,
   parameter logic [XLEN-1:0] TRAP_VEC   = 'h10
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ready,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_target,
   input  logic            trap_req,
   input  logic            halt_req,
   input  logic            resume,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_plus_step,
   output logic            pc_valid,
   output logic            halted,
   output logic            pending,
   output logic            misalign
);

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   localparam logic [XLEN-1:0] c_step = XLEN'(STEP);

   state_t          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            pending_q, pending_d;
   logic [XLEN-1:0] tgt_q, tgt_d;
   logic            misalign_q, misalign_d;
   logic            w_misaligned;

   // A target is misaligned when any of its low log2(STEP) bits are set.
   // With STEP=1 every address is aligned.
   generate
      if (STEP > 1) begin : g_align_chk
         localparam int unsigned c_align_bits = $clog2(STEP);
         assign w_misaligned = (redirect_target[c_align_bits-1:0] != '0);
      end else begin : g_no_align_chk
         assign w_misaligned = 1'b0;
      end
   endgenerate

   assign pc_plus_step = pc_q + c_step;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      pending_d  = pending_q;
      tgt_d      = tgt_q;
      misalign_d = 1'b0;

      case (state_q)
         ST_BOOT: begin
            // trap_req and halt_req are ignored while booting.
            state_d = ST_RUN;
            if (redirect_valid) begin
               if (w_misaligned) begin
                  pc_d       = TRAP_VEC;
                  misalign_d = 1'b1;
                  pending_d  = 1'b0;
               end else begin
                  pending_d = 1'b1;
                  tgt_d     = redirect_target;
               end
            end
         end

         ST_HALT: begin
            // PC holds; redirects are queued (newest wins) until resume.
            if (redirect_valid) begin
               if (w_misaligned) begin
                  pc_d       = TRAP_VEC;
                  misalign_d = 1'b1;
                  pending_d  = 1'b0;
               end else begin
                  pending_d = 1'b1;
                  tgt_d     = redirect_target;
               end
            end
            if (resume) begin
               state_d = ST_RUN;
            end
         end

         ST_RUN: begin
            if (trap_req) begin
               pc_d      = TRAP_VEC;
               pending_d = 1'b0;
            end else if (halt_req) begin
               // Halt wins over resume here; a same-cycle redirect is kept
               // in the pending buffer rather than dropped. A misaligned one
               // still vectors to the trap handler since it cannot be queued.
               state_d = ST_HALT;
               if (redirect_valid) begin
                  if (w_misaligned) begin
                     pc_d       = TRAP_VEC;
                     misalign_d = 1'b1;
                     pending_d  = 1'b0;
                  end else begin
                     pending_d = 1'b1;
                     tgt_d     = redirect_target;
                  end
               end
            end else if (redirect_valid && w_misaligned) begin
               pc_d       = TRAP_VEC;
               misalign_d = 1'b1;
               pending_d  = 1'b0;
            end else if (redirect_valid) begin
               if (ready) begin
                  pc_d      = redirect_target;
                  pending_d = 1'b0;
               end else begin
                  // Stalled: buffer the target, overwriting any older one.
                  pending_d = 1'b1;
                  tgt_d     = redirect_target;
               end
            end else if (pending_q && ready) begin
               pc_d      = tgt_q;
               pending_d = 1'b0;
            end else if (ready) begin
               pc_d = pc_plus_step;
            end
         end

         default: begin
            state_d   = ST_BOOT;
            pc_d      = RESET_ADDR;
            pending_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_BOOT;
         pc_q       <= RESET_ADDR;
         pending_q  <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         pending_q  <= pending_d;
         misalign_q <= misalign_d;
      end
   end

   // Buffer contents are only meaningful while pending_q is set, so no reset.
   always_ff @(posedge clk) begin
      tgt_q <= tgt_d;
   end

   assign pc       = pc_q;
   assign pc_valid = (state_q == ST_RUN);
   assign halted   = (state_q == ST_HALT);
   assign pending  = pending_q;
   assign misalign = misalign_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_sequencer
// Purpose  : Directed self-checking bench for pc_sequencer. Two instances
//            share stimulus: u_dut (STEP=1) and u_dut4 (STEP=4).
// Revision : 1.0  initial release
// ============================================================================
module tb_pc_sequencer;

   logic        clk;
   logic        rst;
   logic        ready;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        trap_req;
   logic        halt_req;
   logic        resume;

   logic [31:0] pc,  pc_plus_step;
   logic        pc_valid,  halted,  pending,  misalign;
   logic [31:0] pc4, pc_plus_step4;
   logic        pc_valid4, halted4, pending4, misalign4;

   int checks = 0;
   int errors = 0;

   pc_sequencer #(.XLEN(32), .STEP(1), .RESET_ADDR(32'h0), .TRAP_VEC(32'h10)) u_dut (
      .clk             (clk),
      .rst             (rst),
      .ready           (ready),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .trap_req        (trap_req),
      .halt_req        (halt_req),
      .resume          (resume),
      .pc              (pc),
      .pc_plus_step    (pc_plus_step),
      .pc_valid        (pc_valid),
      .halted          (halted),
      .pending         (pending),
      .misalign        (misalign)
   );

   pc_sequencer #(.XLEN(32), .STEP(4), .RESET_ADDR(32'h0), .TRAP_VEC(32'h10)) u_dut4 (
      .clk             (clk),
      .rst             (rst),
      .ready           (ready),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .trap_req        (trap_req),
      .halt_req        (halt_req),
      .resume          (resume),
      .pc              (pc4),
      .pc_plus_step    (pc_plus_step4),
      .pc_valid        (pc_valid4),
      .halted          (halted4),
      .pending         (pending4),
      .misalign        (misalign4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Advance one clock; return 1 time unit after the edge for sampling.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; ready = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
      trap_req = 1'b0; halt_req = 1'b0; resume = 1'b0;
      step(); step();

      // Reset state
      chk("rst_pc",       pc,           32'h0);
      chk("rst_pcps",     pc_plus_step, 32'h1);
      chk("rst_valid",    {31'b0, pc_valid}, 32'h0);
      chk("rst_halted",   {31'b0, halted},   32'h0);
      chk("rst_pending",  {31'b0, pending},  32'h0);
      chk("rst_misalign", {31'b0, misalign}, 32'h0);
      chk("rst_pcps4",    pc_plus_step4, 32'h4);

      // Free-run: BOOT for one cycle, then 0,1,2,3
      rst = 1'b0; ready = 1'b1;
      step();
      chk("run_valid", {31'b0, pc_valid}, 32'h1);
      chk("run_pc0",   pc, 32'h0);
      step(); chk("run_pc1", pc, 32'h1);
      step(); chk("run_pc2", pc, 32'h2);
      step(); chk("run_pc3", pc, 32'h3);
      step(); step();
      chk("run_pc5", pc, 32'h5);

      // Buffered redirect, newest wins
      ready = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h40;
      step();
      chk("buf1_pc",   pc, 32'h5);
      chk("buf1_pend", {31'b0, pending}, 32'h1);
      redirect_target = 32'h80;
      step();
      chk("buf2_pc",   pc, 32'h5);
      chk("buf2_pend", {31'b0, pending}, 32'h1);
      redirect_valid = 1'b0;
      step();
      chk("buf3_pc",   pc, 32'h5);
      ready = 1'b1;
      step();
      chk("buf_apply_pc",   pc, 32'h80);
      chk("buf_apply_pend", {31'b0, pending}, 32'h0);
      step();
      chk("buf_next_pc", pc, 32'h81);

      // Halt with queued redirect, then resume
      redirect_valid = 1'b1; redirect_target = 32'h8;
      step();
      chk("to8_pc", pc, 32'h8);
      halt_req = 1'b1; redirect_target = 32'h20;
      step();
      chk("halt_halted", {31'b0, halted},   32'h1);
      chk("halt_valid",  {31'b0, pc_valid}, 32'h0);
      chk("halt_pc",     pc, 32'h8);
      chk("halt_pend",   {31'b0, pending},  32'h1);
      halt_req = 1'b0; redirect_valid = 1'b0;
      step();
      chk("halt_hold_pc", pc, 32'h8);
      resume = 1'b1;
      step();
      chk("resume_valid",  {31'b0, pc_valid}, 32'h1);
      chk("resume_halted", {31'b0, halted},   32'h0);
      chk("resume_pc",     pc, 32'h8);
      resume = 1'b0;
      step();
      chk("resume_apply_pc",   pc, 32'h20);
      chk("resume_apply_pend", {31'b0, pending}, 32'h0);

      // halt_req and resume together: state decides
      halt_req = 1'b1; resume = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h30;
      step();
      chk("both_run_halted", {31'b0, halted},  32'h1);
      chk("both_run_pend",   {31'b0, pending}, 32'h1);
      redirect_valid = 1'b0;
      step();
      chk("both_halt_valid", {31'b0, pc_valid}, 32'h1);
      chk("both_halt_pc",    pc, 32'h20);
      resume = 1'b0; ready = 1'b0;
      step();
      chk("rehalt_halted", {31'b0, halted},  32'h1);
      chk("rehalt_pend",   {31'b0, pending}, 32'h1);

      // Reset mid-halt with pending set
      rst = 1'b1; halt_req = 1'b0; ready = 1'b1;
      step();
      chk("mid_rst_pc",     pc, 32'h0);
      chk("mid_rst_halted", {31'b0, halted},   32'h0);
      chk("mid_rst_valid",  {31'b0, pc_valid}, 32'h0);
      chk("mid_rst_pend",   {31'b0, pending},  32'h0);

      // Wrap and trap priority
      rst = 1'b0;
      step();
      chk("wrap_boot_pc", pc, 32'h0);
      redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFF;
      step();
      chk("wrap_top_pc",   pc, 32'hFFFF_FFFF);
      chk("wrap_top_pcps", pc_plus_step, 32'h0);
      redirect_valid = 1'b0;
      step();
      chk("wrap_pc", pc, 32'h0);
      ready = 1'b0; trap_req = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h50;
      step();
      chk("trap_pc",   pc, 32'h10);
      chk("trap_pend", {31'b0, pending}, 32'h0);
      trap_req = 1'b0; redirect_valid = 1'b0;

      // Misaligned target on STEP=4 instance
      rst = 1'b1; ready = 1'b1;
      step();
      rst = 1'b0;
      step();
      chk("mis_start_pc4", pc4, 32'h0);
      redirect_valid = 1'b1; redirect_target = 32'h42;
      step();
      chk("mis_pc4",       pc4, 32'h10);
      chk("mis_flag4",     {31'b0, misalign4}, 32'h1);
      chk("mis_pend4",     {31'b0, pending4},  32'h0);
      chk("mis_pc1",       pc, 32'h42);
      chk("mis_flag1",     {31'b0, misalign},  32'h0);
      redirect_valid = 1'b0;
      step();
      chk("mis_clear4",    {31'b0, misalign4}, 32'h0);
      chk("mis_next_pc4",  pc4, 32'h14);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter XLEN, 32, address width in bits.
REQ-002 SHALL have parameter STEP, 1, address increment per instruction; power of two (1 = word-addressed, 4 = byte-addressed).
REQ-003 SHALL have parameter RESET_ADDR, 0, PC value loaded on reset.
REQ-004 SHALL have parameter TRAP_VEC, 'h10, PC value loaded on trap or misaligned redirect.
REQ-005 SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-006 SHALL have port ready  in  1  downstream accepts the current PC; PC may advance.
REQ-007 SHALL have ports redirect_valid  in  1 and redirect_target  in  XLEN: branch/jump request and its target.
REQ-008 SHALL have port trap_req  in  1  exception request.
REQ-009 SHALL have ports halt_req  in  1 and resume  in  1: enter and leave the halted state.
REQ-010 SHALL have port pc  out  XLEN  current PC (registered).
REQ-011 SHALL have port pc_plus_step  out  XLEN  pc + STEP (combinational).
REQ-012 SHALL have ports pc_valid  out  1, halted  out  1, pending  out  1 and misalign  out  1.

Function
REQ-013 SHALL implement states BOOT, RUN and HALT.
REQ-014 SHALL drive pc_valid=1 only in RUN and halted=1 only in HALT.
REQ-015 SHALL compute pc_plus_step as (pc + STEP) mod 2^XLEN, wrapping to 0 with no flag.
REQ-016 BOOT SHALL transition to RUN after exactly one cycle, unconditionally.
REQ-017 In RUN, the next-PC priority SHALL be, highest first: trap_req; halt_req; misaligned redirect; redirect; pending; sequential; hold.
- trap_req: pc <= TRAP_VEC regardless of ready; pending cleared.
- halt_req: state <= HALT; pc holds; a same-cycle redirect_valid is latched into pending, not lost.
- redirect_valid with ready=1: pc <= redirect_target; pending cleared.
- redirect_valid with ready=0: target latched into the pending buffer; pending=1; pc holds.
- pending=1, ready=1, no redirect_valid: pc <= buffered target; pending cleared.
- ready=1 otherwise: pc <= pc_plus_step.
- ready=0 otherwise: pc holds.
REQ-018 A new redirect arriving while pending=1 and ready=0 SHALL overwrite the buffer (newest wins).
REQ-019 A redirect is misaligned when redirect_target mod STEP != 0 (low log2(STEP) bits nonzero); with STEP=1, redirects are never misaligned.
REQ-020 A misaligned redirect, when it would otherwise be applied or latched, SHALL set pc <= TRAP_VEC, pulse misalign=1 for exactly one cycle, and clear pending.
REQ-021 In BOOT, redirect_valid SHALL be latched into pending; trap_req and halt_req SHALL be ignored.
REQ-022 In HALT, pc SHALL hold.
- trap_req and halt_req ignored.
- redirect_valid latched into pending (newest wins).
- resume=1: state <= RUN; pending, if set, applies on the first RUN cycle with ready=1.
REQ-023 resume SHALL be ignored outside HALT.
REQ-024 When halt_req and resume are both asserted, the current state SHALL decide: in RUN halt_req acts; in HALT resume acts.

Reset
REQ-025 rst=1 at a rising edge SHALL set state=BOOT, pc=RESET_ADDR, pending=0, misalign=0, pc_valid=0, halted=0; with pc_plus_step = RESET_ADDR+STEP.
REQ-026 rst SHALL override every other input in the same cycle, including mid-redirect, mid-halt and pending=1.
REQ-027 The pending buffer contents SHALL be don't-care after reset; only the pending flag is defined.

Verification
REQ-028 Reset then free-run: STEP=1, ready=1 -> pc_valid rises one cycle after rst falls; pc sequence 0,1,2,3.
REQ-029 Buffered redirect: ready=0 at pc=5; redirect_valid to 0x40, then 0x80 -> pending=1 and pc=5 throughout; ready=1 -> pc=0x80, pending=0, then 0x81.
REQ-030 Misaligned target: STEP=4; redirect_valid to 0x42 -> pc=TRAP_VEC; misalign high exactly one cycle; pending=0.
REQ-031 Halt/resume with queued redirect: halt_req and redirect_valid to 0x20 together at pc=8 -> halted=1, pc=8, pending=1; resume with ready=1 -> pc_valid=1 at pc=8, then pc=0x20.
REQ-032 Trap priority and wrap: pc=0xFFFFFFFF, STEP=1, ready=1 -> next pc=0; trap_req with redirect_valid and ready=0 -> pc=TRAP_VEC, pending=0.
REQ-033 Reset mid-operation: rst asserted while halted=1 and pending=1 -> pc=RESET_ADDR, state=BOOT, pending=0, halted=0.
